fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the bare PC register and incrementer with a PC generator, a request/grant instruction-memory interface with multiple requests in flight, and a prefetch FIFO that decouples fetch from decode stalls. A redirect input from the branch-resolution stage flushes the FIFO and discards stale responses. The block sits between instruction memory and the IF/ID pipeline register.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/sync_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide constants shared by the RV32 pipeline blocks
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response and decode-side handshake
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_incr_o;

    // fetch unit side
    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_incr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    // memory, branch-resolution and decode side
    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_incr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush; head is read straight from storage
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && count != CW'(DEPTH);
    assign dout    = mem[rd_ptr];

    // storage and pointers; flush empties the queue but keeps stale data in place
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, pipelined imem request/grant and prefetch FIFO with redirect flush
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc, tag;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     outstanding, drop_cnt, tag_count, fifo_count;
    logic              grant, accept, pop;

    // only issue when every in-flight response is guaranteed a FIFO slot
    assign bus.imem_req_o = !rst && !bus.redirect_i && drop_cnt == '0 &&
                            {1'b0, fifo_count} + {1'b0, outstanding} < (CW + 1)'(DEPTH);
    assign grant  = bus.imem_req_o && bus.imem_gnt_i;
    assign accept = bus.imem_rvalid_i && drop_cnt == '0 && !bus.redirect_i && tag_count != '0;
    assign pop    = bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i;

    assign bus.imem_addr_o   = pc;
    assign bus.instr_valid_o = fifo_count != '0;
    assign bus.instr_o       = head[XLEN-1:0];
    assign bus.pc_o          = head[2*XLEN-1:XLEN];
    assign bus.pc_incr_o     = head[2*XLEN-1:XLEN] + XLEN'(4);

    // fetch address, in-flight count and stale-response discard counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(bus.imem_rvalid_i);
            if (bus.redirect_i) begin
                pc       <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
                drop_cnt <= outstanding - CW'(bus.imem_rvalid_i);
            end else begin
                if (grant) pc <= pc + XLEN'(4);
                if (bus.imem_rvalid_i && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (accept),
        .flush (bus.redirect_i),
        .din   (pc),
        .dout  (tag),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_prefetch (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .flush (bus.redirect_i),
        .din   ({tag, bus.imem_rdata_i}),
        .dout  (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors plus hand sequences for redirect and grant stall
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    logic gnt_en = 1'b0;
    logic resp_en = 1'b0;
    logic [31:0] pend [$];

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct packed {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive memory inputs for this cycle, settle, and log any grant for a later response
    task automatic apply();
        bus.imem_gnt_i = gnt_en;
        if (resp_en && pend.size() != 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = pend.pop_front() ^ 32'hA5A5_A5A5;
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
        #1;
        if (bus.imem_req_o && bus.imem_gnt_i) pend.push_back(bus.imem_addr_o);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        pend.delete();
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;
        gnt_en  = 1'b0;
        resp_en = 1'b0;
        apply();
        tick();
        for (int i = 0; i < 2; i++) begin
            apply();
            if (check) begin
                chk("rst_req", 32'(bus.imem_req_o), 32'd0);
                chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
                chk("rst_instr", bus.instr_o, 32'd0);
                chk("rst_pc", bus.pc_o, 32'd0);
                chk("rst_pc_incr", bus.pc_incr_o, 32'd4);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    // advance until the FIFO head is valid or the budget runs out; leaves the cycle unticked
    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            apply();
            if (bus.instr_valid_o) break;
            tick();
        end
        chk("wait_valid", 32'(bus.instr_valid_o), 32'd1);
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;

        // backpressure for 7 cycles, then streaming at one instruction per cycle
        vecs[0]  = '{1'b0, 1'b0 | 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        vecs[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

        do_reset(1'b1);
        gnt_en  = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.instr_ready_i = vecs[i].ready;
            apply();
            chk($sformatf("v%0d_req", i), 32'(bus.imem_req_o), 32'(vecs[i].req));
            chk($sformatf("v%0d_addr", i), bus.imem_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid_o), 32'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i), bus.pc_o, vecs[i].pc);
                chk($sformatf("v%0d_instr", i), bus.instr_o, vecs[i].pc ^ 32'hA5A5_A5A5);
                chk($sformatf("v%0d_pc_incr", i), bus.pc_incr_o, vecs[i].pc + 32'd4);
            end
            tick();
        end

        // redirect with two requests outstanding and responses held back
        do_reset(1'b0);
        gnt_en = 1'b1;
        bus.instr_ready_i = 1'b1;
        apply();
        tick();
        apply();
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        apply();
        chk("rd2_req_in_redirect", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.redirect_i = 1'b0;
        resp_en = 1'b1;
        apply();
        chk("rd2_drop0_req", 32'(bus.imem_req_o), 32'd0);
        chk("rd2_drop0_valid", 32'(bus.instr_valid_o), 32'd0);
        tick();
        apply();
        chk("rd2_drop1_req", 32'(bus.imem_req_o), 32'd0);
        chk("rd2_drop1_valid", 32'(bus.instr_valid_o), 32'd0);
        tick();
        apply();
        chk("rd2_new_req", 32'(bus.imem_req_o), 32'd1);
        chk("rd2_new_addr", bus.imem_addr_o, 32'h100);
        tick();
        wait_valid(8);
        chk("rd2_pc", bus.pc_o, 32'h100);
        chk("rd2_instr", bus.instr_o, 32'h100 ^ 32'hA5A5_A5A5);
        tick();

        // redirect to an unaligned target coincident with a pop and a response
        do_reset(1'b0);
        gnt_en  = 1'b1;
        resp_en = 1'b1;
        bus.instr_ready_i = 1'b1;
        apply();
        tick();
        apply();
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h103;
        apply();
        chk("rdp_head_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("rdp_rvalid_present", 32'(pend.size()), 32'd0);
        chk("rdp_req_in_redirect", 32'(bus.imem_req_o), 32'd0);
        tick();
        bus.redirect_i = 1'b0;
        apply();
        chk("rdp_fifo_empty", 32'(bus.instr_valid_o), 32'd0);
        chk("rdp_req", 32'(bus.imem_req_o), 32'd1);
        chk("rdp_addr", bus.imem_addr_o, 32'h100);
        tick();
        wait_valid(8);
        chk("rdp_pc", bus.pc_o, 32'h100);
        chk("rdp_instr", bus.instr_o, 32'h100 ^ 32'hA5A5_A5A5);
        tick();

        // grant withheld for three cycles
        do_reset(1'b0);
        resp_en = 1'b1;
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply();
            chk($sformatf("stall%0d_req", i), 32'(bus.imem_req_o), 32'd1);
            chk($sformatf("stall%0d_addr", i), bus.imem_addr_o, 32'h0);
            tick();
        end
        gnt_en = 1'b1;
        apply();
        chk("stall_grant_addr", bus.imem_addr_o, 32'h0);
        tick();
        gnt_en = 1'b0;
        apply();
        chk("stall_next_req", 32'(bus.imem_req_o), 32'd1);
        chk("stall_next_addr", bus.imem_addr_o, 32'h4);
        tick();
        apply();
        chk("stall_hold_addr", bus.imem_addr_o, 32'h4);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
